ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 32: data and address width; legal value 32 only, checked at elaboration.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent in REQ plus WAIT before a memory access is aborted; legal range 2..255.
REQ-003 Parameter ALIGN_CHECK, default 1: when 1, misaligned loads and stores are trapped.
REQ-004 Port widths (W = XLEN); clock and reset are fixed.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ins_i  in  32  instruction.
- ins_addr_i  in  W  PC of ins_i.
- ins_valid_i  in  1  ins_i is valid this cycle.
- rs1_data_i  in  W  rs1 operand value.
- rs2_data_i  in  W  rs2 operand value.
- rd_addr_o  out  5  writeback register index.
- rd_data_o  out  W  writeback value.
- rd_wr_en_o  out  1  writeback strobe.
- jump_addr_o  out  W  branch/jump target.
- jump_en_o  out  1  redirect strobe.
- hold_flag_o  out  1  stall request to upstream.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  W  memory byte address.
- mem_size_o  out  3  access size: 1, 2 or 4 bytes.
- mem_wdata_o  out  W  store data, lane-aligned.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  load data valid.
- mem_rdata_i  in  W  load data (full word).
- misalign_o  out  1  misaligned-access trap pulse.
- bus_err_o  out  1  timeout trap pulse.

Function
REQ-005 Accept rule: an instruction is accepted when ins_valid_i=1 and the FSM is in IDLE; ins_valid_i is ignored in every other state.
REQ-006 Supported opcodes: OP-IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE; any other opcode, or an illegal funct3/funct7, produces no strobe.
REQ-007 Non-memory instructions: results are registered; rd_wr_en_o, jump_en_o, rd_data_o, rd_addr_o and jump_addr_o are valid exactly 1 cycle after acceptance; strobes last 1 cycle.
REQ-008 Arithmetic: all arithmetic is modulo 2^W; shift amount is op2[4:0]; SLT/BLT compare signed, SLTU/BLTU compare unsigned; SLT results are zero-extended 0/1.
REQ-009 JAL/JALR: rd_data_o=PC+4; JALR target is (rs1+imm_I) with bit 0 cleared.
REQ-010 Branches: jump_en_o=1 only when the condition is true; jump_addr_o=PC+imm_B.
REQ-011 Writes to rd=0 are suppressed: rd_wr_en_o stays 0.
REQ-012 FSM states are IDLE, REQ and WAIT.
- IDLE->REQ: on an accepted LOAD or STORE that is aligned, or when ALIGN_CHECK=0.
- REQ->IDLE: on mem_gnt_i for a store.
- REQ->WAIT: on mem_gnt_i for a load.
- WAIT->IDLE: on mem_rvalid_i.
REQ-013 Memory signals: mem_req_o=1 throughout REQ; mem_addr_o, mem_we_o, mem_size_o and mem_wdata_o are captured at acceptance and held stable until grant.
REQ-014 Store data is replicated into the byte lanes selected by addr[1:0]: SB places byte<<8*addr[1:0]; SH places half<<16*addr[1]; SW places the full word.
REQ-015 Load writeback: rd_wr_en_o pulses in the cycle after mem_rvalid_i.
- The selected lane is extracted from addr[1:0].
- LB/LH sign-extend from bit 7/15 of the selected lane; LBU/LHU zero-extend.
REQ-016 Misalignment (ALIGN_CHECK=1): a halfword with addr[0]=1, or a word with addr[1:0]!=0, issues no request; misalign_o pulses 1 cycle after acceptance and the FSM stays in IDLE.
REQ-017 Timeout: a counter clears on entry to REQ and increments every cycle in REQ or WAIT. On reaching TIMEOUT:
- mem_req_o drops;
- bus_err_o pulses 1 cycle;
- no writeback occurs;
- the FSM returns to IDLE;
- a late mem_rvalid_i arriving in IDLE is ignored.
REQ-018 Simultaneous events: grant and timeout in the same cycle resolve as grant; rvalid and timeout in the same cycle resolve as rvalid.
REQ-019 hold_flag_o is combinational: 1 when the FSM is not in IDLE, or when it is in IDLE with an accepted memory instruction present; 0 in the completion cycle of the access.

Reset
REQ-020 While rst_n=0, asynchronously:
- FSM=IDLE;
- counter=0;
- all outputs 0, including mem_req_o, strobes and data/address outputs.
REQ-021 Reset asserted mid-access abandons the access; no writeback or error pulse follows reset release.

Verification
REQ-022 ADDI x5,x0,-1 -> next cycle rd_addr_o=5, rd_data_o=FFFFFFFF, rd_wr_en_o=1 for 1 cycle.
REQ-023 BLT with rs1=FFFFFFFF, rs2=1, PC=100, imm=-8 -> jump_en_o=1, jump_addr_o=F8; BLTU with the same operands -> jump_en_o=0.
REQ-024 LB x6, addr=0x103, mem_rdata_i=80AABBCC, grant after 2 cycles and rvalid 1 cycle later -> rd_data_o=FFFFFF80; hold_flag_o is high from acceptance until the writeback cycle.
REQ-025 SH with addr=0x102, rs2=1234ABCD -> mem_wdata_o=ABCD0000, mem_size_o=2, mem_we_o=1; SH with addr=0x101 -> no mem_req_o, misalign_o pulses once.
REQ-026 LW with mem_gnt_i held 0 and TIMEOUT=16 -> mem_req_o drops after 16 cycles, bus_err_o pulses, rd_wr_en_o stays 0, and the next ADDI executes normally.
REQ-027 rst_n pulsed low while in WAIT -> mem_req_o=0 immediately, FSM=IDLE; a subsequent mem_rvalid_i produces no writeback.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with registered ALU/branch results and a
// REQ/WAIT load-store FSM that has lane alignment, misalign trap and timeout.
module ex_stage #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT     = 16,
  parameter int ALIGN_CHECK = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ins_i,
  input  logic [XLEN-1:0] ins_addr_i,
  input  logic            ins_valid_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wr_en_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            jump_en_o,
  output logic            hold_flag_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [2:0]      mem_size_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            misalign_o,
  output logic            bus_err_o
);
  localparam int W = XLEN;
  localparam logic [6:0] OP_IMM = 7'h13, OP = 7'h33, LUI = 7'h37, AUIPC = 7'h17,
                         JAL = 7'h6f, JALR = 7'h67, BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23;
  if (XLEN != 32 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
    $error("ex_stage: XLEN must be 32 and TIMEOUT within 2..255");
  end
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, nxt;
  logic [6:0] op, f7;
  logic [2:0] f3, ld_f3;
  logic [4:0] rd, ld_rd;
  logic [W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, op2, alu, sra, wb_val, j_addr;
  logic [W-1:0] addr_n, wdata_n, sh, ld_val;
  logic [2:0] size_n;
  logic [7:0] cnt;
  logic alu_ok, br_take, wb_en, j_en, is_load, is_store, is_mem, misal;
  logic acc, mem_go, tout, abort, ld_done;
  assign op    = ins_i[6:0];
  assign rd    = ins_i[11:7];
  assign f3    = ins_i[14:12];
  assign f7    = ins_i[31:25];
  assign imm_i = {{20{ins_i[31]}}, ins_i[31:20]};
  assign imm_s = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
  assign imm_b = {{20{ins_i[31]}}, ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
  assign imm_u = {ins_i[31:12], 12'b0};
  assign imm_j = {{12{ins_i[31]}}, ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
  assign op2   = op == OP ? rs2_data_i : imm_i;
  assign sra   = $signed(rs1_data_i) >>> op2[4:0];
  assign alu_ok = op == OP_IMM ? (f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1)
                               : (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
  assign br_take = f3[2:1] != 2'b01 &&
                   ((f3[2:1] == 2'b00 ? rs1_data_i == rs2_data_i :
                     f3[1] ? rs1_data_i < rs2_data_i : $signed(rs1_data_i) < $signed(rs2_data_i)) ^ f3[0]);
  always_comb begin
    case (f3)
      3'd0:    alu = (op == OP && f7[5]) ? rs1_data_i - op2 : rs1_data_i + op2;
      3'd1:    alu = rs1_data_i << op2[4:0];
      3'd2:    alu = {{(W-1){1'b0}}, $signed(rs1_data_i) < $signed(op2)};
      3'd3:    alu = {{(W-1){1'b0}}, rs1_data_i < op2};
      3'd4:    alu = rs1_data_i ^ op2;
      3'd5:    alu = f7[5] ? sra : rs1_data_i >> op2[4:0];
      3'd6:    alu = rs1_data_i | op2;
      default: alu = rs1_data_i & op2;
    endcase
  end
  always_comb begin
    wb_en  = 1'b0;
    wb_val = alu;
    j_en   = 1'b0;
    j_addr = ins_addr_i + imm_b;
    case (op)
      OP_IMM, OP: wb_en = alu_ok;
      LUI:        begin wb_en = 1'b1; wb_val = imm_u; end
      AUIPC:      begin wb_en = 1'b1; wb_val = ins_addr_i + imm_u; end
      JAL:        begin wb_en = 1'b1; wb_val = ins_addr_i + W'(4); j_en = 1'b1; j_addr = ins_addr_i + imm_j; end
      JALR:       begin wb_en = f3 == 3'd0; wb_val = ins_addr_i + W'(4); j_en = f3 == 3'd0;
                        j_addr = (rs1_data_i + imm_i) & {{(W-1){1'b1}}, 1'b0}; end
      BRANCH:     j_en = br_take;
      default:    ;
    endcase
  end
  assign is_load  = op == LOAD && f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
  assign is_store = op == STORE && f3 < 3'd3;
  assign is_mem   = is_load || is_store;
  assign addr_n   = rs1_data_i + (is_store ? imm_s : imm_i);
  assign size_n   = f3[1:0] == 2'd0 ? 3'd1 : f3[1:0] == 2'd1 ? 3'd2 : 3'd4;
  assign misal    = ALIGN_CHECK != 0 && ((f3[1:0] == 2'd1 && addr_n[0]) || (f3[1:0] == 2'd2 && addr_n[1:0] != 2'd0));
  assign wdata_n  = f3[1:0] == 2'd0 ? W'(rs2_data_i[7:0]) << {addr_n[1:0], 3'b0} :
                    f3[1:0] == 2'd1 ? W'(rs2_data_i[15:0]) << {addr_n[1], 4'b0} : rs2_data_i;
  assign sh       = mem_rdata_i >> {mem_addr_o[1:0], 3'b0};
  assign ld_val   = ld_f3 == 3'd0 ? {{24{sh[7]}}, sh[7:0]} : ld_f3 == 3'd1 ? {{16{sh[15]}}, sh[15:0]} :
                    ld_f3 == 3'd4 ? {24'b0, sh[7:0]} : ld_f3 == 3'd5 ? {16'b0, sh[15:0]} : sh;
  assign acc     = ins_valid_i && state == IDLE;
  assign mem_go  = acc && is_mem && !misal;
  assign tout    = cnt >= 8'(TIMEOUT - 1);
  assign ld_done = state == WAIT && mem_rvalid_i;
  // grant/rvalid take priority over a timeout landing in the same cycle
  assign abort   = tout && ((state == REQ && !mem_gnt_i) || (state == WAIT && !mem_rvalid_i));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  always_comb begin
    nxt = state == IDLE ? (mem_go ? REQ : IDLE) :
          state == REQ  ? (mem_gnt_i ? (mem_we_o ? IDLE : WAIT) : tout ? IDLE : REQ) :
          (mem_rvalid_i || tout) ? IDLE : WAIT;
  end
  always_comb begin
    mem_req_o   = state == REQ;
    hold_flag_o = rst_n && (state != IDLE || mem_go);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; rd_addr_o <= '0; rd_data_o <= '0; rd_wr_en_o <= 1'b0;
      jump_addr_o <= '0; jump_en_o <= 1'b0; misalign_o <= 1'b0; bus_err_o <= 1'b0;
      mem_we_o <= 1'b0; mem_addr_o <= '0; mem_size_o <= '0; mem_wdata_o <= '0;
      ld_rd <= '0; ld_f3 <= '0;
    end else begin
      cnt        <= state == IDLE ? '0 : cnt + 8'd1;
      rd_wr_en_o <= (acc && wb_en && rd != 5'd0) || (ld_done && ld_rd != 5'd0);
      jump_en_o  <= acc && j_en;
      misalign_o <= acc && is_mem && misal;
      bus_err_o  <= abort;
      if (acc && !is_mem) begin
        rd_addr_o   <= rd;
        rd_data_o   <= wb_val;
        jump_addr_o <= j_addr;
      end
      if (ld_done) begin
        rd_addr_o <= ld_rd;
        rd_data_o <= ld_val;
      end
      if (mem_go) begin
        mem_we_o    <= is_store;
        mem_addr_o  <= addr_n;
        mem_size_o  <= size_n;
        mem_wdata_o <= wdata_n;
        ld_rd       <= rd;
        ld_f3       <= f3;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven scoreboard for ALU/branch ops plus hand-written
// load/store, misalign, timeout and reset-abort sequences.
module tb_ex_stage;
  localparam int TIMEOUT = 16;
  localparam logic [6:0] OPIMM = 7'h13, LOAD = 7'h03;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] ins_i = '0, ins_addr_i = '0, rs1_data_i = '0, rs2_data_i = '0, mem_rdata_i = '0;
  logic ins_valid_i = 1'b0, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [4:0] rd_addr_o;
  logic [31:0] rd_data_o, jump_addr_o, mem_addr_o, mem_wdata_o;
  logic [2:0] mem_size_o;
  logic rd_wr_en_o, jump_en_o, hold_flag_o, mem_req_o, mem_we_o, misalign_o, bus_err_o;

  ex_stage #(.XLEN(32), .TIMEOUT(TIMEOUT), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst_n(rst_n), .ins_i(ins_i), .ins_addr_i(ins_addr_i), .ins_valid_i(ins_valid_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .rd_wr_en_o(rd_wr_en_o), .jump_addr_o(jump_addr_o), .jump_en_o(jump_en_o), .hold_flag_o(hold_flag_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_size_o(mem_size_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o));

  always #5 clk = ~clk;

  typedef struct {
    int id;
    logic [31:0] ins, pc, a, b;
    logic wr;
    logic [4:0] rd;
    logic [31:0] data;
    logic jen;
    logic [31:0] jaddr;
  } vec_t;
  vec_t vt[$];
  vec_t sb[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, 5'd0, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 10'd0, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 10'd0, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 10'd0, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic void add(input logic [31:0] ins, pc, a, b, input logic wr, input logic [4:0] rd,
                              input logic [31:0] data, input logic jen, input logic [31:0] jaddr);
    vec_t v;
    v.id = vt.size(); v.ins = ins; v.pc = pc; v.a = a; v.b = b;
    v.wr = wr; v.rd = rd; v.data = data; v.jen = jen; v.jaddr = jaddr;
    vt.push_back(v);
  endfunction

  task automatic issue(input logic [31:0] ins, pc, a, b);
    ins_i = ins; ins_addr_i = pc; rs1_data_i = a; rs2_data_i = b; ins_valid_i = 1'b1;
  endtask

  task automatic cmp(input vec_t e);
    chk($sformatf("vec%0d rd_wr_en", e.id), 32'(rd_wr_en_o), 32'(e.wr));
    chk($sformatf("vec%0d jump_en", e.id), 32'(jump_en_o), 32'(e.jen));
    if (e.wr) begin
      chk($sformatf("vec%0d rd_addr", e.id), 32'(rd_addr_o), 32'(e.rd));
      chk($sformatf("vec%0d rd_data", e.id), rd_data_o, e.data);
    end
    if (e.jen) chk($sformatf("vec%0d jump_addr", e.id), jump_addr_o, e.jaddr);
  endtask

  task automatic do_store(input logic [31:0] ins, a, b, addr, wdata, input logic [2:0] size, input string nm);
    @(negedge clk) issue(ins, 32'h0, a, b);
    @(negedge clk) ins_valid_i = 1'b0;
    chk({nm, " req"}, 32'(mem_req_o), 32'd1);
    chk({nm, " we"}, 32'(mem_we_o), 32'd1);
    chk({nm, " addr"}, mem_addr_o, addr);
    chk({nm, " wdata"}, mem_wdata_o, wdata);
    chk({nm, " size"}, 32'(mem_size_o), 32'(size));
    mem_gnt_i = 1'b1;
    @(negedge clk) mem_gnt_i = 1'b0;
    chk({nm, " req done"}, 32'(mem_req_o), 32'd0);
    chk({nm, " hold done"}, 32'(hold_flag_o), 32'd0);
    chk({nm, " no wb"}, 32'(rd_wr_en_o), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] ins, a, rdata, exp, input logic [4:0] rd, input string nm);
    @(negedge clk) issue(ins, 32'h0, a, 32'h0);
    @(negedge clk) ins_valid_i = 1'b0;
    chk({nm, " req"}, 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk) mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    @(negedge clk) mem_rvalid_i = 1'b0;
    chk({nm, " wr"}, 32'(rd_wr_en_o), 32'd1);
    chk({nm, " rd"}, 32'(rd_addr_o), 32'(rd));
    chk({nm, " data"}, rd_data_o, exp);
  endtask

  task automatic misaligned(input logic [31:0] ins, input string nm);
    @(negedge clk) issue(ins, 32'h0, 32'h100, 32'h1234ABCD);
    #1 chk({nm, " hold"}, 32'(hold_flag_o), 32'd0);
    @(negedge clk) ins_valid_i = 1'b0;
    chk({nm, " misalign"}, 32'(misalign_o), 32'd1);
    chk({nm, " req"}, 32'(mem_req_o), 32'd0);
    @(negedge clk);
    chk({nm, " misalign end"}, 32'(misalign_o), 32'd0);
    chk({nm, " req after"}, 32'(mem_req_o), 32'd0);
    chk({nm, " no wb"}, 32'(rd_wr_en_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic seen;
    add(enc_i(12'hFFF, 3'd0, 5'd5, OPIMM), 32'h0, 32'h0, 32'h0, 1, 5'd5, 32'hFFFFFFFF, 0, 32'h0);
    add(enc_r(7'h00, 3'd0, 5'd1), 32'h0, 32'd5, 32'd7, 1, 5'd1, 32'd12, 0, 32'h0);
    add(enc_r(7'h20, 3'd0, 5'd2), 32'h0, 32'd5, 32'd7, 1, 5'd2, 32'hFFFFFFFE, 0, 32'h0);
    add(enc_r(7'h00, 3'd2, 5'd3), 32'h0, 32'hFFFFFFFF, 32'd1, 1, 5'd3, 32'd1, 0, 32'h0);
    add(enc_r(7'h00, 3'd3, 5'd4), 32'h0, 32'hFFFFFFFF, 32'd1, 1, 5'd4, 32'd0, 0, 32'h0);
    add(enc_r(7'h20, 3'd5, 5'd6), 32'h0, 32'h80000000, 32'd4, 1, 5'd6, 32'hF8000000, 0, 32'h0);
    add(enc_r(7'h00, 3'd5, 5'd7), 32'h0, 32'h80000000, 32'd4, 1, 5'd7, 32'h08000000, 0, 32'h0);
    add(enc_r(7'h00, 3'd1, 5'd8), 32'h0, 32'd1, 32'd33, 1, 5'd8, 32'd2, 0, 32'h0);
    add(enc_i(12'h0FF, 3'd4, 5'd9, OPIMM), 32'h0, 32'h0F0F, 32'h0, 1, 5'd9, 32'h0FF0, 0, 32'h0);
    add(enc_i(12'h403, 3'd5, 5'd10, OPIMM), 32'h0, 32'h80000000, 32'h0, 1, 5'd10, 32'hF0000000, 0, 32'h0);
    add({20'h12345, 5'd11, 7'h37}, 32'h0, 32'h0, 32'h0, 1, 5'd11, 32'h12345000, 0, 32'h0);
    add({20'h00001, 5'd12, 7'h17}, 32'h100, 32'h0, 32'h0, 1, 5'd12, 32'h1100, 0, 32'h0);
    add(enc_j(21'h20, 5'd13), 32'h100, 32'h0, 32'h0, 1, 5'd13, 32'h104, 1, 32'h120);
    add(enc_i(12'h004, 3'd0, 5'd14, 7'h67), 32'h100, 32'h201, 32'h0, 1, 5'd14, 32'h104, 1, 32'h204);
    add(enc_b(13'h1FF8, 3'd4), 32'h100, 32'hFFFFFFFF, 32'd1, 0, 5'd0, 32'h0, 1, 32'hF8);
    add(enc_b(13'h1FF8, 3'd6), 32'h100, 32'hFFFFFFFF, 32'd1, 0, 5'd0, 32'h0, 0, 32'h0);
    add(enc_b(13'h0010, 3'd0), 32'h200, 32'd9, 32'd9, 0, 5'd0, 32'h0, 1, 32'h210);
    add(enc_b(13'h0010, 3'd1), 32'h200, 32'd9, 32'd9, 0, 5'd0, 32'h0, 0, 32'h0);
    add(enc_i(12'h001, 3'd0, 5'd0, OPIMM), 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0);
    add(32'h0000007F, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0);
    add(enc_r(7'h01, 3'd0, 5'd15), 32'h0, 32'd1, 32'd1, 0, 5'd0, 32'h0, 0, 32'h0);
    add(enc_i(12'h401, 3'd1, 5'd16, OPIMM), 32'h0, 32'd1, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0);

    // reset state, with a load presented that must not be held or requested
    issue(enc_i(12'h0, 3'd2, 5'd1, LOAD), 32'h0, 32'h100, 32'h0);
    #12;
    chk("reset rd_wr_en", 32'(rd_wr_en_o), 32'd0);
    chk("reset jump_en", 32'(jump_en_o), 32'd0);
    chk("reset mem_req", 32'(mem_req_o), 32'd0);
    chk("reset hold", 32'(hold_flag_o), 32'd0);
    chk("reset rd_data", rd_data_o, 32'h0);
    chk("reset mem_addr", mem_addr_o, 32'h0);
    chk("reset bus_err", 32'(bus_err_o), 32'd0);
    ins_valid_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      if (sb.size() != 0) cmp(sb.pop_front());
      issue(vt[i].ins, vt[i].pc, vt[i].a, vt[i].b);
      sb.push_back(vt[i]);
    end
    @(negedge clk) ins_valid_i = 1'b0;
    cmp(sb.pop_front());
    @(negedge clk);
    chk("strobe one cycle", 32'(jump_en_o | rd_wr_en_o), 32'd0);

    // LB x6 at 0x103, grant after two REQ cycles, rvalid one cycle later
    @(negedge clk) issue(enc_i(12'h003, 3'd0, 5'd6, LOAD), 32'h0, 32'h100, 32'h0);
    #1 chk("lb hold accept", 32'(hold_flag_o), 32'd1);
    @(negedge clk) ins_valid_i = 1'b0;
    chk("lb req", 32'(mem_req_o), 32'd1);
    chk("lb addr", mem_addr_o, 32'h103);
    chk("lb size", 32'(mem_size_o), 32'd1);
    chk("lb we", 32'(mem_we_o), 32'd0);
    chk("lb hold req", 32'(hold_flag_o), 32'd1);
    @(negedge clk);
    chk("lb req 2", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk) mem_gnt_i = 1'b0;
    chk("lb req wait", 32'(mem_req_o), 32'd0);
    chk("lb hold wait", 32'(hold_flag_o), 32'd1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80AABBCC;
    @(negedge clk) mem_rvalid_i = 1'b0;
    chk("lb wr", 32'(rd_wr_en_o), 32'd1);
    chk("lb rd", 32'(rd_addr_o), 32'd6);
    chk("lb data", rd_data_o, 32'hFFFFFF80);
    chk("lb hold wb", 32'(hold_flag_o), 32'd0);
    @(negedge clk);
    chk("lb wr pulse", 32'(rd_wr_en_o), 32'd0);

    do_load(enc_i(12'h002, 3'd5, 5'd7, LOAD), 32'h100, 32'h80AABBCC, 32'h000080AA, 5'd7, "lhu");
    do_load(enc_i(12'h001, 3'd4, 5'd8, LOAD), 32'h100, 32'h80AABBCC, 32'h000000BB, 5'd8, "lbu");
    do_load(enc_i(12'h004, 3'd2, 5'd9, LOAD), 32'h100, 32'h13579BDF, 32'h13579BDF, 5'd9, "lw");
    do_store(enc_s(12'h002, 3'd1), 32'h100, 32'h1234ABCD, 32'h102, 32'hABCD0000, 3'd2, "sh");
    do_store(enc_s(12'h001, 3'd0), 32'h100, 32'h000000EF, 32'h101, 32'h0000EF00, 3'd1, "sb");
    do_store(enc_s(12'h004, 3'd2), 32'h100, 32'hDEADBEEF, 32'h104, 32'hDEADBEEF, 3'd4, "sw");
    misaligned(enc_s(12'h001, 3'd1), "sh mis");
    misaligned(enc_i(12'h002, 3'd2, 5'd3, LOAD), "lw mis");

    // LW with no grant: timeout, error pulse, late rvalid ignored
    @(negedge clk) issue(enc_i(12'h000, 3'd2, 5'd7, LOAD), 32'h0, 32'h100, 32'h0);
    @(negedge clk) ins_valid_i = 1'b0;
    cyc = 0; seen = 1'b0;
    while (mem_req_o && cyc < 40) begin
      cyc++;
      if (rd_wr_en_o || bus_err_o) seen = 1'b1;
      @(negedge clk);
    end
    chk("timeout req cycles", 32'(cyc), 32'(TIMEOUT));
    chk("timeout quiet during", 32'(seen), 32'd0);
    chk("timeout bus_err", 32'(bus_err_o), 32'd1);
    chk("timeout no wb", 32'(rd_wr_en_o), 32'd0);
    chk("timeout hold", 32'(hold_flag_o), 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
    @(negedge clk) mem_rvalid_i = 1'b0;
    chk("bus_err pulse", 32'(bus_err_o), 32'd0);
    chk("late rvalid no wb", 32'(rd_wr_en_o), 32'd0);
    issue(enc_i(12'd42, 3'd0, 5'd7, OPIMM), 32'h0, 32'h0, 32'h0);
    @(negedge clk) ins_valid_i = 1'b0;
    chk("post timeout addi wr", 32'(rd_wr_en_o), 32'd1);
    chk("post timeout addi data", rd_data_o, 32'd42);

    // grant in the last REQ cycle wins, rvalid in a timed-out WAIT cycle wins
    @(negedge clk) issue(enc_i(12'h000, 3'd2, 5'd8, LOAD), 32'h0, 32'h100, 32'h0);
    @(negedge clk) ins_valid_i = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("edge gnt req", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk) mem_gnt_i = 1'b0;
    chk("edge gnt no err", 32'(bus_err_o), 32'd0);
    chk("edge gnt wait hold", 32'(hold_flag_o), 32'd1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11223344;
    @(negedge clk) mem_rvalid_i = 1'b0;
    chk("edge rvalid wr", 32'(rd_wr_en_o), 32'd1);
    chk("edge rvalid data", rd_data_o, 32'h11223344);
    chk("edge rvalid no err", 32'(bus_err_o), 32'd0);

    // reset while in REQ drops the request at once and leaves nothing behind
    @(negedge clk) issue(enc_i(12'h000, 3'd2, 5'd9, LOAD), 32'h0, 32'h100, 32'h0);
    @(negedge clk) ins_valid_i = 1'b0;
    chk("rst req before", 32'(mem_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst req async", 32'(mem_req_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (TIMEOUT + 4) begin
      @(negedge clk);
      if (bus_err_o || rd_wr_en_o || mem_req_o || hold_flag_o) seen = 1'b1;
    end
    chk("rst req aftermath", 32'(seen), 32'd0);

    // reset while in WAIT, then a stray rvalid
    @(negedge clk) issue(enc_i(12'h000, 3'd2, 5'd10, LOAD), 32'h0, 32'h100, 32'h0);
    @(negedge clk) ins_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk) mem_gnt_i = 1'b0;
    chk("rst wait hold", 32'(hold_flag_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst wait req", 32'(mem_req_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst wait idle", 32'(hold_flag_o), 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    @(negedge clk) mem_rvalid_i = 1'b0;
    chk("rst wait no wb", 32'(rd_wr_en_o), 32'd0);
    @(negedge clk);
    chk("rst wait no wb 2", 32'(rd_wr_en_o), 32'd0);
    chk("rst wait no err", 32'(bus_err_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
